// File: rtl/pipeline_register_if.sv
// Handshake/data bundle for pipeline_register.
// The master drives the input side; the slave is the register chain.
interface pipeline_register_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output en,
    output flush,
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  en,
    input  flush,
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output count
  );
endinterface

// File: rtl/pipeline_register.sv
// DEPTH-stage WIDTH-bit register chain with per-stage valid bits,
// stall, flush and an occupancy count.
module pipeline_register #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  pipeline_register_if.slave bus
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (bus.flush) begin
      data_d  = '{default: '0};
      valid_d = '0;
      count_d = '0;
    end else if (bus.en) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Invalid slots carry zero data so out_data is 0 when idle.
      data_d[0]  = bus.in_valid ? bus.in_data : '0;
      valid_d[0] = bus.in_valid;
      count_d    = count_q
                 + CW'(bus.in_valid)
                 - CW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '{default: '0};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_pipeline_register.sv
// Bench: three pipeline_register instances driven in lockstep and
// compared each cycle against a history-log model.
module tb_pipeline_register;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_register_if #(.WIDTH(8),  .DEPTH(4)) b4 ();
  pipeline_register_if #(.WIDTH(16), .DEPTH(1)) b1 ();
  pipeline_register_if #(.WIDTH(16), .DEPTH(7)) b7 ();

  pipeline_register #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );
  pipeline_register #(.WIDTH(16), .DEPTH(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );
  pipeline_register #(.WIDTH(16), .DEPTH(7)) u7 (
    .clk (clk),
    .rst (rst),
    .bus (b7)
  );

  // One entry per advancing edge since the last clear: {valid, data}.
  logic [16:0] hist [$];

  int total = 0;
  int fails = 0;

  function automatic logic [16:0] exp_out(int d);
    int n = hist.size();
    if (n >= d) return hist[n-d];
    return 17'h0;
  endfunction

  function automatic int exp_cnt(int d);
    int n = hist.size();
    int c = 0;
    int lo = (n > d) ? n - d : 0;
    for (int j = lo; j < n; j++)
      c += int'(hist[j][16]);
    return c;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [16:0] e;
    e = exp_out(4);
    chk("d4_valid", 32'(b4.out_valid), 32'(e[16]));
    chk("d4_data", 32'(b4.out_data), 32'(e[7:0]));
    chk("d4_count", 32'(b4.count), 32'(exp_cnt(4)));
    chk("d4_count_le_depth", 32'(b4.count <= 3'd4), 32'd1);
    e = exp_out(1);
    chk("d1_valid", 32'(b1.out_valid), 32'(e[16]));
    chk("d1_data", 32'(b1.out_data), 32'(e[15:0]));
    chk("d1_count", 32'(b1.count), 32'(exp_cnt(1)));
    e = exp_out(7);
    chk("d7_valid", 32'(b7.out_valid), 32'(e[16]));
    chk("d7_data", 32'(b7.out_data), 32'(e[15:0]));
    chk("d7_count", 32'(b7.count), 32'(exp_cnt(7)));
    chk("d7_count_le_depth", 32'(b7.count <= 3'd7), 32'd1);
  endtask

  task automatic step(input bit r, input bit f, input bit e,
                      input bit v, input logic [15:0] d);
    rst         = r;
    b4.flush    = f;
    b1.flush    = f;
    b7.flush    = f;
    b4.en       = e;
    b1.en       = e;
    b7.en       = e;
    b4.in_valid = v;
    b1.in_valid = v;
    b7.in_valid = v;
    b4.in_data  = d[7:0];
    b1.in_data  = d;
    b7.in_data  = d;
    @(posedge clk);
    if (r || f)
      hist.delete();
    else if (e)
      hist.push_back(v ? {1'b1, d} : 17'h0);
    #1;
    check_all();
  endtask

  initial begin
    // Reset held two edges with a valid item presented.
    step(1, 0, 1, 1, 16'h00AA);
    chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
    step(1, 0, 1, 1, 16'h00AA);
    chk("rst_count", 32'(b4.count), 32'd0);
    step(0, 0, 1, 1, 16'h00AA);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'h0000);

    // Streaming 01..08, then drain.
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 1, 16'(i));
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 16'h0000);

    // Bubbles.
    step(0, 0, 1, 1, 16'h0011);
    step(0, 0, 1, 0, 16'h00FF);
    step(0, 0, 1, 1, 16'h0022);
    step(0, 0, 1, 0, 16'h00FF);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'h0000);

    // Stall with a competing item that must be lost.
    step(0, 0, 1, 1, 16'h0033);
    step(0, 0, 1, 1, 16'h0044);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h0099);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'h0000);

    // Flush wins over en; its input is dropped.
    step(0, 0, 1, 1, 16'h0001);
    step(0, 0, 1, 1, 16'h0002);
    step(0, 0, 1, 1, 16'h0003);
    step(0, 1, 1, 1, 16'h0055);
    chk("flush_count", 32'(b4.count), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'h0000);

    // Full-width passthrough.
    step(0, 0, 1, 1, 16'hBEEF);
    step(0, 0, 1, 1, 16'h1234);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1, 16'(i * 16'h1111));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      automatic int x = $urandom_range(0, 99);
      step(x < 2, (x >= 2) && (x < 5),
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 1) == 1,
           16'($urandom_range(0, 65535)));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/pipeline_register.md
Name: pipeline_register

Overview:
Parametrised multi-stage register chain, generalising the single D flip-flop to WIDTH-bit data, DEPTH stages and per-stage valid tracking. Adds synchronous reset, a global stall enable and a flush. Used in the MAC datapath to delay and align operands and partial products between the multiplier and the accumulator stages. It also reports how many stages currently hold valid data.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of register stages and latency in cycles (>=1)
CW, $clog2(DEPTH+1), width of the occupancy count (derived, do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  advance enable; 0 = stall, every stage holds
flush  input  1  synchronous clear of all stages (not a reset; count also cleared)
in_valid  input  1  in_data is valid this cycle
in_data  input  WIDTH  data into stage 0
out_valid  output  1  valid bit of stage DEPTH-1
out_data  output  WIDTH  data of stage DEPTH-1
count  output  CW  number of stages with valid bit set (0..DEPTH)

Behaviour:
- State: stage_data[0..DEPTH-1] (WIDTH each), stage_valid[0..DEPTH-1], count register.
- Outputs are registered state only: out_data = stage_data[DEPTH-1], out_valid = stage_valid[DEPTH-1]. No combinational path from any input to any output.
- Reset: while rst=1 at a rising edge, all stage_data = 0, all stage_valid = 0, count = 0. So out_data = 0, out_valid = 0 and count = 0 from the first edge with rst high.
- Priority at each rising edge: rst > flush > en > hold.
- flush=1 (rst=0): same clearing as reset. The input that cycle is dropped regardless of en and in_valid.
- en=1, rst=0, flush=0:
  - stage 0 loads in_valid and loads (in_valid ? in_data : 0).
  - stage i loads stage i-1 data and valid, for i = 1..DEPTH-1.
- Data gating: a stage whose valid bit is 0 always holds data 0. Hence out_data = 0 whenever out_valid = 0.
- en=0, rst=0, flush=0: every stage and count hold their values. in_data and in_valid are ignored, so an item presented while stalled is lost. The producer must hold it.
- Latency: an item accepted at edge N (en=1, in_valid=1) appears on the outputs after edge N+DEPTH-1. It is visible for the cycle following that edge, counting only edges with en=1.
- DEPTH=1: stage 0 is the output stage; the chain degenerates to one enabled D flip-flop with valid bit.
- count update on an advancing edge: count_next = count + in_valid - stage_valid[DEPTH-1].
  - Simultaneous entry and exit leaves count unchanged.
  - count never exceeds DEPTH and never underflows, because it always equals the popcount of stage_valid. The bench must check this invariant every cycle.
- Arithmetic is unsigned. Data is passed through unmodified with no width change.
- Reset or flush mid-stream discards all in-flight items. There are no partial outputs afterwards, and the next valid output is the first item accepted after the clear.

Test Plan:
- Reset: drive rst=1 for 2 edges with in_valid=1, in_data=8'hAA, en=1 -> out_valid=0, out_data=0, count=0 throughout; after release, 8'hAA accepted on the first rst=0 edge appears 4 edges later.
- Streaming, DEPTH=4: feed 8'h01..8'h08 on consecutive edges with en=1 -> out_data 8'h01..8'h08 on consecutive cycles starting after the 4th edge; count reads 1,2,3,4,4,4,4,4 then falls 3,2,1,0 once in_valid=0.
- Bubbles: in_valid pattern 1,0,1,0 with data 8'h11,8'hFF,8'h22,8'hFF -> outputs (1,8'h11),(0,8'h00),(1,8'h22),(0,8'h00); count peaks at 2.
- Stall: load 8'h33 and 8'h44, then en=0 for 3 edges with in_valid=1, in_data=8'h99 -> outputs and count frozen, 8'h99 never emerges; after en=1 resumes, 8'h33 and 8'h44 emerge with total latency 4 advancing edges.
- Flush vs. en: pipe holding 3 valid items, assert flush=1 with en=1, in_valid=1, in_data=8'h55 -> next cycle out_valid=0, count=0, and 8'h55 is never output.
- Parameter sweep: repeat streaming with WIDTH=16, DEPTH=1 (latency 1, count in {0,1}) and DEPTH=7 (latency 7, count max 7, CW=3), using data 16'hBEEF/16'h1234 to check full-width passthrough.
